maxnet_loader: RTL and testbench
================================

Name: maxnet_loader

Overview:
- Writer side of the Maxnet memory interface: fills the 4 input activations (X) and 16 weights (W) that the Maxnet datapath reads.
- Accepts a valid/ready word stream from the host or testbench and stores the words in register files.
- Presents the stored words as flat buses and raises data_valid once the full set is loaded.
- Holds the contents stable until the controller releases them, so a new problem can only load after the current one finishes.

Parameters:
- WIDTH, 32, bits per word (activation or weight).
- N, 4, neuron count; stores N X words and N*N W words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_data holds a word.
- in_data  input  WIDTH  streamed word.
- in_ready  output  1  loader accepts a word this cycle.
- release  input  1  controller finished with the stored set; re-arm the loader.
- data_valid  output  1  full set stored and stable.
- busy  output  1  at least one word of the current set accepted, set not yet complete.
- x_flat  output  N*WIDTH  X[i] at bits [i*WIDTH +: WIDTH].
- w_flat  output  N*N*WIDTH  W[k] at bits [k*WIDTH +: WIDTH].
- chk_err  output  1  checksum mismatch flag (see Optional Feature).

Behaviour:
- Transfer rule: a word transfers on a rising clk when in_valid && in_ready. in_ready is decoded from the registered state only, with no combinational path from in_valid.
- Word order:
  - Words 0..N-1 go to X[0..N-1].
  - Words N..N+N*N-1 go to W[0..N*N-1], row-major: W[N*k+j] is weight j of processing unit k.
- Index counter: width clog2(N+N*N+1), increments on each transfer. Word index selects the target register.
- State machine:
  - IDLE: in_ready=1, busy=0. First transfer goes to LOAD.
  - LOAD: in_ready=1, busy=1. The transfer of word N+N*N-1 goes to FULL (or CHECK when the macro is defined).
  - FULL: in_ready=0, busy=0, data_valid=1. release=1 goes to IDLE and clears the counter.
- Storage is never cleared by release: x_flat and w_flat keep their last values until overwritten word by word.
- data_valid falls the cycle after release is sampled.
- release in IDLE or LOAD is ignored; a partial load continues.
- release and in_valid together in FULL: release wins, no word is taken that cycle, and the next cycle is IDLE with in_ready=1.
- Reset: state IDLE, counter 0, all X/W registers 0, so x_flat=0 and w_flat=0. in_ready=1 from the first cycle after reset. data_valid=0, busy=0, chk_err=0.
- Reset mid-load discards the partial set.
- Throughput: one word per cycle. data_valid rises the cycle after the last word transfers, so a full set takes N+N*N cycles from the first transfer to data_valid=1.
- Back-pressure: in_valid low stalls the loader with no state change. No timeout.

Optional Feature:
- Macro: MAXNET_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all accepted data words is kept, cleared on entry to IDLE.
  - After the last weight, state CHECK (in_ready=1, busy=1) accepts one extra word.
  - On that transfer: go to FULL, set chk_err = (word != running XOR).
  - chk_err holds until release or rst.
  - data_valid rises regardless; the controller uses chk_err.
- Undefined: no CHECK state, no checksum register, chk_err tied 0.

Test Plan:
- Reset then stream X={5,3,9,1} and W=row-major 4x4 with diagonal 1 and off-diagonal 0xFFFFFFF0, in_valid held high -> in_ready=1 for 20 cycles. data_valid=1 on the cycle after word 19. x_flat[95:64]=9, w_flat[31:0]=1, w_flat[63:32]=0xFFFFFFF0.
- Same stream with in_valid toggled every other cycle -> identical final contents. data_valid rises 1 cycle after the 20th accepted word. busy=1 throughout.
- In FULL, drive in_valid=1 with data 0xDEAD for 5 cycles -> in_ready=0 and x_flat/w_flat unchanged. Assert release with in_valid=1 -> next cycle data_valid=0, in_ready=1, 0xDEAD not stored. The following cycle's word is stored to X[0].
- Reset asserted after 7 words -> next cycle x_flat=0, w_flat=0, busy=0. A fresh 20-word load completes normally.
- release pulsed during LOAD after word 10 -> ignored. Load completes after word 19 with all values correct.
- With MAXNET_LOADER_CHECKSUM_EN defined:
  - Send the 20 words plus their correct XOR -> data_valid=1, chk_err=0.
  - Repeat with the XOR word bit-flipped -> data_valid=1, chk_err=1.
  - After release -> chk_err=0.

Source files
------------

// File: rtl/maxnet_loader.sv
// maxnet_loader: writer side of the Maxnet memory interface.
// Takes a valid/ready word stream and stores N activations (X) followed by
// N*N row-major weights (W). The full set is held stable, with data_valid
// high, until the controller releases it.
// The controller's release input is named release_set because "release"
// is a reserved word in SystemVerilog.
// Optional build macro: MAXNET_LOADER_CHECKSUM_EN. When it is defined, the
// loader takes one extra word after the last weight and compares it with
// the running XOR of the data words. The result drives chk_err.
//
// state | meaning
// IDLE  | empty or released, waiting for the first word of a new set
// LOAD  | part of the set has been accepted
// CHECK | all data stored, waiting for the checksum word (macro builds only)
// FULL  | set complete and held until release_set
module maxnet_loader #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   release_set,
  output logic                   data_valid,
  output logic                   busy,
  output logic [N*WIDTH-1:0]     x_flat,
  output logic [N*N*WIDTH-1:0]   w_flat,
  output logic                   chk_err
);

  localparam int TOTAL = N + N*N;
  localparam int IW    = $clog2(TOTAL + 1);

`ifdef MAXNET_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, FULL, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
`endif

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] x_mem [N];
  logic [WIDTH-1:0] w_mem [N*N];
  logic             xfer;
  logic             wr_en;
  logic             last_word;

`ifdef MAXNET_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] csum;
`endif

  // A transfer stores a word only while the index still points at X or W.
  // In CHECK the index has reached TOTAL, so the checksum word is never stored.
  assign xfer      = in_valid && in_ready;
  assign wr_en     = xfer && (idx < IW'(TOTAL));
  assign last_word = (idx == IW'(TOTAL - 1));

  // Sequencing FSM: index counter, running checksum and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      data_valid <= 1'b0;
`ifdef MAXNET_LOADER_CHECKSUM_EN
      csum       <= '0;
      chk_err    <= 1'b0;
`endif
    end else begin
      if (wr_en) begin
        idx <= idx + IW'(1);
      end
`ifdef MAXNET_LOADER_CHECKSUM_EN
      if (wr_en) begin
        csum <= csum ^ in_data;
      end
`endif
      case (state)
        IDLE: begin
          if (xfer) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer && last_word) begin
`ifdef MAXNET_LOADER_CHECKSUM_EN
            state      <= CHECK;
`else
            state      <= FULL;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b1;
`endif
          end
        end
`ifdef MAXNET_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            state      <= FULL;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b1;
            chk_err    <= (in_data != csum);
          end
        end
`endif
        FULL: begin
          // in_ready is low here, so a word offered with release is never taken.
          if (release_set) begin
            state      <= IDLE;
            idx        <= '0;
            in_ready   <= 1'b1;
            data_valid <= 1'b0;
`ifdef MAXNET_LOADER_CHECKSUM_EN
            csum       <= '0;
            chk_err    <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef MAXNET_LOADER_CHECKSUM_EN
  assign chk_err = 1'b0;
`endif

  // Register files: the word index selects one X or W entry. Only reset clears the entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        x_mem[i] <= '0;
      end
      for (int k = 0; k < N*N; k++) begin
        w_mem[k] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < N; i++) begin
        if (idx == IW'(i)) begin
          x_mem[i] <= in_data;
        end
      end
      for (int k = 0; k < N*N; k++) begin
        if (idx == IW'(N + k)) begin
          w_mem[k] <= in_data;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_x_flat
    assign x_flat[g*WIDTH +: WIDTH] = x_mem[g];
  end

  for (genvar g = 0; g < N*N; g++) begin : g_w_flat
    assign w_flat[g*WIDTH +: WIDTH] = w_mem[g];
  end

endmodule

// File: tb/tb_maxnet_loader.sv
// Testbench for maxnet_loader. A word-count model of the loader is compared
// with the DUT on every falling edge. Directed scenarios and a random phase
// drive the stimulus, and literal checks at chosen points confirm the model.
// The checksum scenarios are compiled only when MAXNET_LOADER_CHECKSUM_EN is defined.
module tb_maxnet_loader;
  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int TOTAL = N + N*N;
`ifdef MAXNET_LOADER_CHECKSUM_EN
  localparam int NEED  = TOTAL + 1;
`else
  localparam int NEED  = TOTAL;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic [WIDTH-1:0]     in_data = '0;
  logic                 release_set = 1'b0;
  logic                 in_ready, data_valid, busy, chk_err;
  logic [N*WIDTH-1:0]   x_flat;
  logic [N*N*WIDTH-1:0] w_flat;

  maxnet_loader #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .release_set(release_set), .data_valid(data_valid),
    .busy(busy), .x_flat(x_flat), .w_flat(w_flat), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en = 1'b0;

  // The model tracks how many words the current set has taken, the stored words and the XOR.
  logic [31:0] m_x [N];
  logic [31:0] m_w [N*N];
  logic [31:0] m_xor;
  int          m_count;
  bit          m_full, m_chk;

  logic [31:0]          stim [TOTAL];
  logic [N*WIDTH-1:0]   exp_x, e_x;
  logic [N*N*WIDTH-1:0] exp_w, e_w;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_x[i] = '0;
      for (int k = 0; k < N*N; k++) m_w[k] = '0;
      m_count = 0; m_full = 0; m_chk = 0; m_xor = '0;
    end else if (m_full) begin
      if (release_set) begin
        m_count = 0; m_full = 0; m_chk = 0; m_xor = '0;
      end
    end else if (in_valid) begin
      if (m_count < N) m_x[m_count] = in_data;
      else if (m_count < TOTAL) m_w[m_count - N] = in_data;
      else m_chk = (in_data != m_xor);
      if (m_count < TOTAL) m_xor = m_xor ^ in_data;
      m_count++;
      if (m_count == NEED) m_full = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) exp_x[i*WIDTH +: WIDTH] = m_x[i];
      for (int k = 0; k < N*N; k++) exp_w[k*WIDTH +: WIDTH] = m_w[k];
      check("in_ready", in_ready, !m_full);
      check("busy", busy, (m_count > 0) && !m_full);
      check("data_valid", data_valid, m_full);
      check("chk_err", chk_err, m_chk);
      check("x_flat", x_flat, exp_x);
      check("w_flat", w_flat, exp_w);
    end
  end

  task automatic cyc(input bit v, input logic [31:0] d, input bit r);
    @(negedge clk);
    in_valid = v; in_data = d; release_set = r;
  endtask

  task automatic idle();
    cyc(1'b0, $urandom, 1'b0);
  endtask

  // Offer a word until the model is able to accept it on the next edge.
  task automatic push(input logic [31:0] d);
    int k;
    for (k = 0; k < 50; k++) begin
      cyc(1'b1, d, 1'b0);
      if (!m_full) break;
    end
    if (k == 50) begin
      n_checks++; n_errors++;
      $display("FAIL push_timeout: got no acceptance expected acceptance within 50 cycles");
    end
  endtask

  task automatic load_from(input int start, input bit toggle, input bit flip);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < TOTAL; i++) x = x ^ stim[i];
    for (int i = start; i < TOTAL; i++) begin
      if (toggle) idle();
      push(stim[i]);
    end
`ifdef MAXNET_LOADER_CHECKSUM_EN
    if (toggle) idle();
    push(x ^ (flip ? 32'h0000_0001 : 32'h0));
`else
    x = x ^ {31'b0, flip};
`endif
  endtask

  task automatic build_expect();
    for (int i = 0; i < N; i++) e_x[i*WIDTH +: WIDTH] = stim[i];
    for (int k = 0; k < N*N; k++) e_w[k*WIDTH +: WIDTH] = stim[N + k];
  endtask

  task automatic set_pattern();
    stim[0] = 32'd5; stim[1] = 32'd3; stim[2] = 32'd9; stim[3] = 32'd1;
    for (int k = 0; k < N*N; k++)
      stim[N + k] = (k / N == k % N) ? 32'd1 : 32'hFFFF_FFF0;
  endtask

  task automatic set_random();
    for (int i = 0; i < TOTAL; i++) stim[i] = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_dv", data_valid, 1'b0);
    check("rst_x", x_flat, '0);

    // Pattern stream with in_valid held high.
    set_pattern();
    load_from(0, 1'b0, 1'b0);
    idle();
    check("t1_dv", data_valid, 1'b1);
    check("t1_x2", x_flat[95:64], 32'd9);
    check("t1_w0", w_flat[31:0], 32'd1);
    check("t1_w1", w_flat[63:32], 32'hFFFF_FFF0);
    check("t1_xall", x_flat, {32'd1, 32'd9, 32'd3, 32'd5});

    // Same stream with in_valid toggled.
    cyc(1'b0, 32'h0, 1'b1);
    load_from(0, 1'b1, 1'b0);
    idle();
    check("t2_dv", data_valid, 1'b1);
    check("t2_xall", x_flat, {32'd1, 32'd9, 32'd3, 32'd5});
    check("t2_w5", w_flat[191:160], 32'd1);

    // Words offered while FULL, then release together with in_valid.
    repeat (5) cyc(1'b1, 32'hDEAD, 1'b0);
    check("t3_hold_x", x_flat, {32'd1, 32'd9, 32'd3, 32'd5});
    check("t3_hold_w0", w_flat[31:0], 32'd1);
    cyc(1'b1, 32'hDEAD, 1'b1);
    cyc(1'b1, 32'h77, 1'b0);
    check("t3_dv_low", data_valid, 1'b0);
    check("t3_ready", in_ready, 1'b1);
    check("t3_no_dead", x_flat[31:0], 32'd5);
    idle();
    check("t3_x0", x_flat[31:0], 32'h77);
    check("t3_busy", busy, 1'b1);
    stim[0] = 32'h77;
    load_from(1, 1'b0, 1'b0);
    idle();
    check("t3_done", data_valid, 1'b1);

    // Reset in the middle of a load.
    cyc(1'b0, 32'h0, 1'b1);
    set_random();
    for (int i = 0; i < 7; i++) push(stim[i]);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_x0", x_flat, '0);
    check("t4_w0", w_flat, '0);
    check("t4_busy", busy, 1'b0);
    check("t4_ready", in_ready, 1'b1);
    set_random();
    load_from(0, 1'b0, 1'b0);
    idle();
    build_expect();
    check("t4_x", x_flat, e_x);
    check("t4_w", w_flat, e_w);

    // release pulses during LOAD are ignored.
    cyc(1'b0, 32'h0, 1'b1);
    set_random();
    for (int i = 0; i <= 10; i++) push(stim[i]);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    check("t5_busy", busy, 1'b1);
    load_from(11, 1'b0, 1'b0);
    idle();
    build_expect();
    check("t5_dv", data_valid, 1'b1);
    check("t5_x", x_flat, e_x);
    check("t5_w", w_flat, e_w);

`ifdef MAXNET_LOADER_CHECKSUM_EN
    cyc(1'b0, 32'h0, 1'b1);
    set_pattern();
    load_from(0, 1'b0, 1'b0);
    idle();
    check("cs_ok_dv", data_valid, 1'b1);
    check("cs_ok_err", chk_err, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    load_from(0, 1'b0, 1'b1);
    idle();
    check("cs_bad_dv", data_valid, 1'b1);
    check("cs_bad_err", chk_err, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    idle();
    check("cs_rel_err", chk_err, 1'b0);
`endif

    // Random phase: valid gaps, release pulses at any time, occasional reset.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 199) == 0);
      in_valid    = ($urandom_range(0, 9) < 7);
      in_data     = $urandom;
      release_set = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; release_set = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
